// File: rtl/match_window_counter_pkg.sv
// Shared definitions for the match window counter: report slot states and
// parameter defaults.
package match_window_counter_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_e;

    localparam int CNT_W_DEF   = 8;
    localparam int WIN_LEN_DEF = 16;

endpackage

// File: rtl/match_window_counter_sat_accum.sv
// Saturating 0/1 increment accumulator with a sticky saturation flag.
// sum/sum_sat expose the value this edge would produce, for close-edge capture.
module sat_accum
    import match_window_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_zero,
    input  logic             inc,
    output logic [CNT_W-1:0] sum,
    output logic             sum_sat
);

    logic [CNT_W-1:0] acc;
    logic             acc_sat;

    // NOTE: every output of a combinational block is assigned before any branch,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        sum     = acc + CNT_W'(inc);
        sum_sat = acc_sat;
        if (inc && (acc == '1)) begin
            sum     = acc;
            sum_sat = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (load_zero) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else begin
            acc     <= sum;
            acc_sat <= sum_sat;
        end
    end

endmodule

// File: rtl/match_window_counter.sv
// Counts match pulses over fixed windows of WIN_LEN cycles and publishes each
// window's count through a one-entry valid/ready slot with a sticky overrun flag.
module match_window_counter
    import match_window_counter_pkg::*;
#(
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int WIN_LEN = WIN_LEN_DEF,
    localparam int WIN_W   = $clog2(WIN_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ans_in,
    input  logic             clr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_overrun
);

    logic [WIN_W-1:0] win_pos;
    logic             close;
    logic [CNT_W-1:0] f_count;
    logic             f_sat;
    slot_e            slot, slot_nxt;
    logic             load_rec;
    logic             drop_rec;

    assign close     = (win_pos == WIN_W'(WIN_LEN - 1));
    assign rpt_valid = (slot == S_FULL);

    sat_accum #(.CNT_W(CNT_W)) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_zero (clr | close),
        .inc       (ans_in),
        .sum       (f_count),
        .sum_sat   (f_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_pos <= '0;
        end else if (clr || close) begin
            win_pos <= '0;
        end else begin
            win_pos <= win_pos + WIN_W'(1);
        end
    end

    always_comb begin
        slot_nxt = slot;
        load_rec = 1'b0;
        drop_rec = 1'b0;
        case (slot)
            S_EMPTY: begin
                if (close) begin
                    load_rec = 1'b1;
                    slot_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (close) begin
                    // A close while the consumer takes the old record is a clean hand-off.
                    load_rec = rpt_ready;
                    drop_rec = !rpt_ready;
                end else if (rpt_ready) begin
                    slot_nxt = S_EMPTY;
                end
            end
            default: slot_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= S_EMPTY;
            rpt_count   <= '0;
            rpt_sat     <= 1'b0;
            rpt_overrun <= 1'b0;
        end else if (clr) begin
            slot        <= S_EMPTY;
            rpt_count   <= '0;
            rpt_sat     <= 1'b0;
            rpt_overrun <= 1'b0;
        end else begin
            slot <= slot_nxt;
            if (load_rec) begin
                rpt_count <= f_count;
                rpt_sat   <= f_sat;
            end
            if (drop_rec) begin
                rpt_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_match_window_counter.sv
// Randomized scoreboard bench for match_window_counter with an arithmetic
// window model; a negedge monitor compares slot contents and flags.
module tb_match_window_counter;

    localparam int CNT_W   = 4;
    localparam int WIN_LEN = 16;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ans_in = 1'b0;
    logic             clr = 1'b0;
    logic             rpt_ready = 1'b0;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_overrun;

    match_window_counter #(.CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ans_in      (ans_in),
        .clr         (clr),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_count   (rpt_count),
        .rpt_sat     (rpt_sat),
        .rpt_overrun (rpt_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit sat;
    } rec_t;

    rec_t     exp_q[$];
    bit [1:0] st_q[$];
    int       n_chk = 0;
    int       n_pass = 0;

    // Reference model: cycle number within the window, raw (unsaturated) pulse
    // total, whether a record is waiting, and the overrun flag.
    int pos;
    int total;
    bit have_pend;
    bit ovr;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        pos       = 0;
        total     = 0;
        have_pend = 1'b0;
        ovr       = 1'b0;
        exp_q.delete();
        st_q.delete();
    endtask

    // Applies one clock edge using the inputs the DUT sampled on it.
    task automatic model_edge();
        rec_t r;
        if (clr) begin
            if (have_pend) exp_q.pop_back();
            pos       = 0;
            total     = 0;
            have_pend = 1'b0;
            ovr       = 1'b0;
        end else begin
            if (have_pend && rpt_ready) have_pend = 1'b0;
            total += int'(ans_in);
            if (pos == WIN_LEN - 1) begin
                r.count = (total > MAX_CNT) ? MAX_CNT : total;
                r.sat   = (total > MAX_CNT);
                if (have_pend) ovr = 1'b1;
                else begin
                    have_pend = 1'b1;
                    exp_q.push_back(r);
                end
                total = 0;
            end
            pos = (pos + 1) % WIN_LEN;
        end
    endtask

    task automatic cycle(input int ans_pct, input int rdy_pct, input int clr_pct);
        @(posedge clk);
        if (rst_n) begin
            model_edge();
            st_q.push_back({have_pend, ovr});
        end
        #1;
        ans_in    = ($urandom_range(99) < ans_pct);
        rpt_ready = ($urandom_range(99) < rdy_pct);
        clr       = ($urandom_range(99) < clr_pct);
    endtask

    // Monitor: checks flags every cycle and the slot record while it is held.
    always @(negedge clk) begin
        if (rst_n) begin
            if (st_q.size() > 0) begin
                bit [1:0] s;
                s = st_q.pop_front();
                check("rpt_valid", int'(rpt_valid), int'(s[1]));
                check("rpt_overrun", int'(rpt_overrun), int'(s[0]));
            end
            if (rpt_valid) begin
                if (exp_q.size() == 0) begin
                    check("record_queue_depth", 0, 1);
                end else begin
                    check("rpt_count", int'(rpt_count), exp_q[0].count);
                    check("rpt_sat", int'(rpt_sat), int'(exp_q[0].sat));
                    if (rpt_ready && !clr) void'(exp_q.pop_front());
                end
            end
        end
    end

    int ans_tab[6] = '{30, 100, 0, 50, 100, 20};
    int rdy_tab[6] = '{100, 100, 0, 30, 10, 60};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int p = 0; p < 6; p++) begin
            repeat (200) cycle(ans_tab[p], rdy_tab[p], (p == 3) ? 2 : 0);
        end

        // Asynchronous reset mid-window with pulses active: outputs drop at once.
        for (int i = 0; i < 2 * WIN_LEN; i++) begin
            cycle(60, 20, 0);
            if (pos == WIN_LEN / 2) break;
        end
        rst_n  = 1'b0;
        ans_in = 1'b1;
        #1;
        check("reset_valid", int'(rpt_valid), 0);
        check("reset_count", int'(rpt_count), 0);
        check("reset_sat", int'(rpt_sat), 0);
        check("reset_overrun", int'(rpt_overrun), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3 * WIN_LEN) cycle(40, 50, 0);

        // Clear taken on a close edge with a pulse and ready present.
        repeat (WIN_LEN) cycle(100, 0, 0);
        for (int i = 0; i < 2 * WIN_LEN; i++) begin
            cycle(50, 0, 0);
            if (pos == WIN_LEN - 1) break;
        end
        check("clr_setup_at_close", pos, WIN_LEN - 1);
        clr       = 1'b1;
        ans_in    = 1'b1;
        rpt_ready = 1'b1;
        cycle(0, 100, 0);
        check("clr_model_pos", pos, 0);
        repeat (3 * WIN_LEN) cycle(70, 40, 0);

        repeat (3) cycle(0, 100, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
